// File: rtl/lfsr_gen.sv
// Parametrised LFSR (Fibonacci or Galois) with load, all-zero lock-up recovery
// and a period monitor that measures the step count from SEED back to SEED.
module lfsr_gen #(
  parameter int unsigned     W    = 4,
  parameter logic [W-1:0]    TAPS = 4'b0011,
  parameter logic [W-1:0]    SEED = '1,
  parameter bit              MODE = 1'b0
) (
  input  logic         c,
  input  logic         l,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] o,
  output logic         so,
  output logic         wrap,
  output logic         lock,
  output logic [W-1:0] per
);

  logic [W-1:0] fib_next;
  logic [W-1:0] gal_next;
  logic [W-1:0] step_next;
  logic [W-1:0] cnt;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    fib_next = {^(o & TAPS), o[W-1:1]};
    gal_next = '0;
    gal_next[W-1] = o[0];
    for (int i = 0; i < int'(W) - 1; i++) begin
      gal_next[i] = o[i+1] ^ (TAPS[i] & o[0]);
    end
    step_next = MODE ? gal_next : fib_next;
  end

  assign so = o[0];

  // NOTE: all state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge c) begin
    if (l) begin
      o    <= SEED;
      cnt  <= '0;
      per  <= '0;
      wrap <= 1'b0;
      lock <= 1'b0;
    end else begin
      wrap <= 1'b0;
      lock <= 1'b0;
      if (ld) begin
        o   <= ld_val;
        cnt <= '0;
      end else if (en) begin
        if (o == '0) begin
          // All-zero is a fixed point of the shift; recover to SEED instead of stepping.
          o    <= SEED;
          cnt  <= '0;
          lock <= 1'b1;
        end else begin
          o <= step_next;
          if (step_next == SEED) begin
            per  <= cnt + 1'b1;
            cnt  <= '0;
            wrap <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
